parklot_multilane_ctrl: RTL and testbench
=========================================

// Module: parklot_multilane_ctrl
// PURPOSE
//  Multi-lane parking-lot occupancy controller. Each lane has two optical
//  sensors (a = outer, b = inner). A per-lane FSM classifies a complete
//  pass as an entry or an exit. A shared saturating counter tracks occupancy
//  against CAPACITY and drives the full/empty flags to the gate/sign logic.
//  It is the parametrised successor of the single-lane exit detector.
// PARAMETERS
//  NUM_LANES        4    number of sensor lanes (1..8)
//  CAPACITY         255  maximum occupancy; count width CW = $clog2(CAPACITY+1)
//  DEBOUNCE_CYCLES  4    stable samples required before a sensor change is
//                        accepted (used only with PARKLOT_DEBOUNCE_EN)
// PORTS
//  clk          in   1            clock
//  reset        in   1            synchronous, active-high
//  ab           in   2*NUM_LANES  lane i sensors {a,b} = ab[2i+1:2i]; asynchronous
//  clr          in   1            synchronous clear of count to 0
//  entry_pulse  out  NUM_LANES    1-cycle pulse per completed entry
//  exit_pulse   out  NUM_LANES    1-cycle pulse per completed exit
//  fault        out  NUM_LANES    high while the lane is in FAULT
//  count        out  CW           current occupancy
//  full         out  1            count == CAPACITY
//  empty        out  1            count == 0
//  sat_err      out  1            1-cycle pulse when an update was clamped
// BEHAVIOUR
//  - Reset: all lanes go to IDLE; pulses, fault and sat_err = 0; count = 0;
//    empty = 1; full = 0. Reset mid-sequence discards the partial pass.
//  - Each ab pair passes through a 2-flop synchroniser (2-cycle latency)
//    before reaching the lane FSM.
//  - Lane FSM states (sampled ab = {a,b}):
//    IDLE: 10 -> EN1; 01 -> EX1; 00 -> IDLE; 11 -> FAULT.
//    EN1: 11 -> EN2; 00 -> IDLE (abort); 10 holds; 01 -> FAULT.
//    EN2: 01 -> EN3; 10 -> EN1 (backtrack); 11 holds; 00 -> FAULT.
//    EN3: 00 -> IDLE and entry; 11 -> EN2; 01 holds; 10 -> FAULT.
//    EX1/EX2/EX3 mirror EN1/EN2/EN3 with a and b swapped; EX3 + 00 -> IDLE
//    and exit.
//    FAULT: holds until ab = 00, then -> IDLE. No event is generated.
//  - entry_pulse[i] / exit_pulse[i] are registered and high for exactly the
//    cycle after the edge that returns the lane to IDLE.
//  - Counter: n_in = popcount(entry_pulse), n_out = popcount(exit_pulse) in
//    the same cycle. next = count + n_in - n_out, computed signed at width
//    CW+2 and clamped to [0, CAPACITY].
//  - sat_err pulses on the following cycle when the clamp was applied.
//  - Simultaneous entry and exit on different lanes net out with no error.
//  - full/empty are registered and consistent with count in the same cycle.
//  - clr has priority over pulses in the same cycle: count becomes 0 and
//    those pulses are dropped. Lane FSMs are unaffected by clr.
// CONFIGURATION
//  PARKLOT_DEBOUNCE_EN
//    Defined: after synchronisation, each sensor bit is accepted only after
//    DEBOUNCE_CYCLES consecutive equal samples. Shorter glitches are ignored.
//    Added latency is DEBOUNCE_CYCLES cycles.
//    Undefined: the synchronised value feeds the FSM directly and
//    DEBOUNCE_CYCLES is unused.
// STRUCTURE
//  - Package parklot_pkg: lane_state_t enum (IDLE, EN1, EN2, EN3, EX1, EX2,
//    EX3, FAULT); sensor pattern constants AB_CLR=00, AB_OUT=10, AB_BOTH=11,
//    AB_IN=01.
//  - Sub-module parklot_lane_fsm (synchroniser, optional debounce, FSM,
//    pulse registers) instantiated NUM_LANES times via generate. The top
//    level holds the popcounts, clamp arithmetic and flags.
// TESTING
//  1. Lane 0 drives 00,10,11,01,00 (each held 3 cycles) from count 0
//     -> entry_pulse[0] once; count = 1; empty falls.
//  2. Lane 1 runs an exit sequence at count 0 -> exit_pulse[1]; count stays
//     0; sat_err pulses once.
//  3. count = 253; lanes 0-3 complete entries in the same cycle -> count =
//     255; full = 1; sat_err = 1.
//  4. Lane 2 drives 10,11,10,00 -> no pulse; count unchanged.
//     Lane 2 drives 10,01 -> fault[2] = 1 until ab = 00.
//  5. Lane 0 entry and lane 1 exit in the same cycle at count 10 -> count = 10,
//     no sat_err. clr during a pulse cycle -> count = 0.
//  6. reset asserted while in EN2 -> IDLE, no pulse. With PARKLOT_DEBOUNCE_EN,
//     a 2-cycle glitch on a is ignored.

Source files
------------

// File: rtl/parklot_pkg.sv
// Shared types and sensor-pattern constants for the multi-lane parking-lot controller.
// Optional sensor debounce is selected with the PARKLOT_DEBOUNCE_EN macro.
package parklot_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN1   = 3'd1,
    EN2   = 3'd2,
    EN3   = 3'd3,
    EX1   = 3'd4,
    EX2   = 3'd5,
    EX3   = 3'd6,
    FAULT = 3'd7
  } lane_state_t;

  // Sensor pairs are always ordered {a, b}: a = outer, b = inner
  localparam logic [1:0] AB_CLR  = 2'b00;
  localparam logic [1:0] AB_OUT  = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;
  localparam logic [1:0] AB_IN   = 2'b01;

endpackage

// File: rtl/parklot_lane_fsm.sv
// One sensor lane: 2-flop synchroniser, optional debounce (PARKLOT_DEBOUNCE_EN),
// pass-classification FSM and registered entry/exit/fault outputs.
module parklot_lane_fsm
  import parklot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ab,
  output logic       entry_pulse,
  output logic       exit_pulse,
  output logic       fault
);

  logic [1:0]  sync1_r;
  logic [1:0]  sync2_r;
  logic [1:0]  ab_q_s;
  lane_state_t state_r;
  logic        entry_r;
  logic        exit_r;
  logic        fault_r;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("parklot_lane_fsm: DEBOUNCE_CYCLES must be at least 1");
  end

  // Two-flop synchroniser for the asynchronous sensor pair
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= ab;
      sync2_r <= sync1_r;
    end
  end

`ifdef PARKLOT_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0][DW-1:0] db_cnt_r;
  logic [1:0]         db_val_r;

  // A bit flips only after DEBOUNCE_CYCLES consecutive samples disagree with it
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_r <= {2{DW'(0)}};
      db_val_r <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == db_val_r[i]) begin
          db_cnt_r[i] <= DW'(0);
        end else if (db_cnt_r[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_val_r[i] <= sync2_r[i];
          db_cnt_r[i] <= DW'(0);
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
        end
      end
    end
  end

  assign ab_q_s = db_val_r;
`else
  assign ab_q_s = sync2_r;
`endif

  // Lane FSM; the exit half mirrors the entry half with a and b swapped
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      entry_r <= 1'b0;
      exit_r  <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      entry_r <= 1'b0;
      exit_r  <= 1'b0;
      fault_r <= 1'b0;
      case (state_r)
        IDLE: case (ab_q_s)
          AB_OUT:  state_r <= EN1;
          AB_IN:   state_r <= EX1;
          AB_BOTH: begin state_r <= FAULT; fault_r <= 1'b1; end
          default: state_r <= IDLE;
        endcase
        EN1: case (ab_q_s)
          AB_BOTH: state_r <= EN2;
          AB_CLR:  state_r <= IDLE;
          AB_IN:   begin state_r <= FAULT; fault_r <= 1'b1; end
          default: state_r <= EN1;
        endcase
        EN2: case (ab_q_s)
          AB_IN:   state_r <= EN3;
          AB_OUT:  state_r <= EN1;
          AB_CLR:  begin state_r <= FAULT; fault_r <= 1'b1; end
          default: state_r <= EN2;
        endcase
        EN3: case (ab_q_s)
          AB_CLR:  begin state_r <= IDLE; entry_r <= 1'b1; end
          AB_BOTH: state_r <= EN2;
          AB_OUT:  begin state_r <= FAULT; fault_r <= 1'b1; end
          default: state_r <= EN3;
        endcase
        EX1: case (ab_q_s)
          AB_BOTH: state_r <= EX2;
          AB_CLR:  state_r <= IDLE;
          AB_OUT:  begin state_r <= FAULT; fault_r <= 1'b1; end
          default: state_r <= EX1;
        endcase
        EX2: case (ab_q_s)
          AB_OUT:  state_r <= EX3;
          AB_IN:   state_r <= EX1;
          AB_CLR:  begin state_r <= FAULT; fault_r <= 1'b1; end
          default: state_r <= EX2;
        endcase
        EX3: case (ab_q_s)
          AB_CLR:  begin state_r <= IDLE; exit_r <= 1'b1; end
          AB_BOTH: state_r <= EX2;
          AB_IN:   begin state_r <= FAULT; fault_r <= 1'b1; end
          default: state_r <= EX3;
        endcase
        FAULT: begin
          if (ab_q_s == AB_CLR) begin
            state_r <= IDLE;
          end else begin
            state_r <= FAULT;
            fault_r <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign entry_pulse = entry_r;
  assign exit_pulse  = exit_r;
  assign fault       = fault_r;

endmodule

// File: rtl/parklot_multilane_ctrl.sv
// Multi-lane parking-lot occupancy controller: per-lane pass detectors feeding a
// shared clamped occupancy counter. Debounce is enabled by PARKLOT_DEBOUNCE_EN.
module parklot_multilane_ctrl
  import parklot_pkg::*;
#(
  parameter int NUM_LANES       = 4,
  parameter int CAPACITY        = 255,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2*NUM_LANES-1:0]          ab,
  input  logic                            clr,
  output logic [NUM_LANES-1:0]            entry_pulse,
  output logic [NUM_LANES-1:0]            exit_pulse,
  output logic [NUM_LANES-1:0]            fault,
  output logic [$clog2(CAPACITY+1)-1:0]   count,
  output logic                            full,
  output logic                            empty,
  output logic                            sat_err
);

  localparam int CW = $clog2(CAPACITY + 1);
  // Signed working width; never narrower than needed to hold +/-8 lane events
  localparam int SW = (CW + 2 > 6) ? CW + 2 : 6;
  localparam logic signed [SW-1:0] CAP_S  = SW'(CAPACITY);
  localparam logic signed [SW-1:0] ZERO_S = SW'(0);

  logic [NUM_LANES-1:0]  entry_s;
  logic [NUM_LANES-1:0]  exit_s;
  logic [3:0]            n_in_s;
  logic [3:0]            n_out_s;
  logic signed [SW-1:0]  sum_s;
  logic [CW-1:0]         next_s;
  logic                  clamp_s;
  logic [CW-1:0]         count_r;
  logic                  full_r;
  logic                  empty_r;
  logic                  sat_r;

  if (NUM_LANES < 1 || NUM_LANES > 8 || CAPACITY < 1) begin : g_bad_cfg
    $error("parklot_multilane_ctrl: NUM_LANES must be 1..8 and CAPACITY >= 1");
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    parklot_lane_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .ab          (ab[2*g +: 2]),
      .entry_pulse (entry_s[g]),
      .exit_pulse  (exit_s[g]),
      .fault       (fault[g])
    );
  end

  // Event popcounts and clamped next occupancy
  always_comb begin
    n_in_s  = 4'd0;
    n_out_s = 4'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n_in_s  = n_in_s  + {3'b000, entry_s[i]};
      n_out_s = n_out_s + {3'b000, exit_s[i]};
    end
    sum_s = $signed(SW'(count_r) + SW'(n_in_s) - SW'(n_out_s));
    if (sum_s < ZERO_S) begin
      next_s  = CW'(0);
      clamp_s = 1'b1;
    end else if (sum_s > CAP_S) begin
      next_s  = CW'(CAPACITY);
      clamp_s = 1'b1;
    end else begin
      next_s  = CW'(sum_s);
      clamp_s = 1'b0;
    end
  end

  // Occupancy register with flags derived from the same next value; clr drops pulses
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_r <= CW'(0);
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      sat_r   <= 1'b0;
    end else begin
      count_r <= next_s;
      full_r  <= (next_s == CW'(CAPACITY));
      empty_r <= (next_s == CW'(0));
      sat_r   <= clamp_s;
    end
  end

  assign entry_pulse = entry_s;
  assign exit_pulse  = exit_s;
  assign count       = count_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign sat_err     = sat_r;

endmodule

// File: tb/tb_parklot_multilane_ctrl.sv
// Self-checking bench for parklot_multilane_ctrl: vector table plus hand sequences,
// with pulses matched against a queue of expected events.
module tb_parklot_multilane_ctrl;

  localparam int NL = 4;
`ifdef PARKLOT_DEBOUNCE_EN
  localparam int HOLD = 8;
`else
  localparam int HOLD = 3;
`endif
  localparam int TAIL = HOLD + 3;
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_ENT  = 2'd1;
  localparam logic [1:0] K_EXT  = 2'd2;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic [7:0]    ab;
  logic [NL-1:0] entry_pulse, exit_pulse, fault;
  logic [7:0]    count;
  logic          full, empty, sat_err;

  parklot_multilane_ctrl #(.NUM_LANES(NL), .CAPACITY(255), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .ab(ab), .clr(clr),
    .entry_pulse(entry_pulse), .exit_pulse(exit_pulse), .fault(fault),
    .count(count), .full(full), .empty(empty), .sat_err(sat_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] kind; logic [2:0] lane; } ev_t;
  typedef struct {
    int              lane;
    logic [5:0][1:0] pats;
    logic [1:0]      kind;
    int              exp_count;
    int              exp_sat;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sat_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_one(input logic [1:0] k, input int i);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_pulse: lane %0d kind %0d with none pending", i, k);
    end else begin
      e = exp_q.pop_front();
      check("pulse_kind", k, e.kind);
      check("pulse_lane", i, e.lane);
    end
  endtask

  always @(negedge clk) begin
    if (sat_err === 1'b1) sat_seen++;
    for (int i = 0; i < NL; i++) begin
      if (entry_pulse[i] === 1'b1) mon_one(K_ENT, i);
      if (exit_pulse[i] === 1'b1)  mon_one(K_EXT, i);
    end
  end

  function automatic logic [7:0] put(input int lane, input logic [1:0] p);
    logic [7:0] v;
    v = 8'h00;
    v[2*lane +: 2] = p;
    return v;
  endfunction

  function automatic ev_t ev(input logic [1:0] k, input int lane);
    ev_t e;
    e.kind = k;
    e.lane = 3'(lane);
    return e;
  endfunction

  task automatic hold(input logic [7:0] v);
    ab = v;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic settle();
    ab = 8'h00;
    repeat (TAIL) @(negedge clk);
  endtask

  task automatic check_cnt(input string tag, input int exp_count, input int sat_base, input int exp_sat);
    check({tag, "_count"}, count, exp_count);
    check({tag, "_empty"}, empty, (exp_count == 0) ? 1 : 0);
    check({tag, "_full"},  full,  (exp_count == 255) ? 1 : 0);
    check({tag, "_sat"},   sat_seen - sat_base, exp_sat);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // All four lanes walk a full entry pass together
  task automatic all_lanes_entry();
    for (int l = 0; l < NL; l++) exp_q.push_back(ev(K_ENT, l));
    hold({4{2'b10}}); hold({4{2'b11}}); hold({4{2'b01}}); hold(8'h00);
  endtask

  task automatic lane_entry(input int lane);
    exp_q.push_back(ev(K_ENT, lane));
    hold(put(lane, 2'b10)); hold(put(lane, 2'b11)); hold(put(lane, 2'b01)); hold(8'h00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  base;
    bit  got;

    vecs[0] = '{0, {2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00}, K_ENT,  1, 0};
    vecs[1] = '{3, {2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00}, K_ENT,  2, 0};
    vecs[2] = '{2, {2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00}, K_EXT,  1, 0};
    vecs[3] = '{2, {2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00}, K_NONE, 1, 0};
    vecs[4] = '{1, {2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00}, K_ENT,  2, 0};
    vecs[5] = '{0, {2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, K_NONE, 2, 0};
    vecs[6] = '{0, {2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00}, K_EXT,  1, 0};
    vecs[7] = '{3, {2'b01, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00}, K_EXT,  0, 0};
    vecs[8] = '{1, {2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00}, K_EXT,  0, 1};

    reset = 1'b1; clr = 1'b0; ab = 8'h00;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_fault", fault, 0);
    check("rst_pulses", {entry_pulse, exit_pulse}, 0);
    check("rst_sat", sat_err, 0);

    // Single-lane table: entries, exits, aborts, backtracks, underflow clamp
    for (int v = 0; v < 9; v++) begin
      base = sat_seen;
      if (vecs[v].kind != K_NONE) exp_q.push_back(ev(vecs[v].kind, vecs[v].lane));
      for (int k = 0; k < 6; k++) hold(put(vecs[v].lane, vecs[v].pats[5-k]));
      settle();
      check_cnt($sformatf("vec%0d", v), vecs[v].exp_count, base, vecs[v].exp_sat);
      check($sformatf("vec%0d_fault", v), fault, 0);
    end

    // Fill to 253, then four simultaneous entries clamp at capacity
    base = sat_seen;
    for (int r = 0; r < 63; r++) all_lanes_entry();
    lane_entry(0);
    settle();
    check_cnt("fill253", 253, base, 0);
    all_lanes_entry();
    settle();
    check_cnt("overflow", 255, base, 1);

    // Aborted pass at full leaves count alone; illegal pattern faults until 00
    base = sat_seen;
    hold(put(2, 2'b10)); hold(put(2, 2'b11)); hold(put(2, 2'b10)); settle();
    check_cnt("abort_full", 255, base, 0);
    hold(put(2, 2'b10)); hold(put(2, 2'b01));
    check("fault_set", fault, 4'b0100);
    hold(put(2, 2'b11));
    check("fault_hold", fault, 4'b0100);
    settle();
    check("fault_clear", fault, 0);
    check_cnt("fault_count", 255, base, 0);

    // Simultaneous entry and exit on different lanes net out
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);
    all_lanes_entry(); all_lanes_entry();
    exp_q.push_back(ev(K_ENT, 0)); exp_q.push_back(ev(K_ENT, 1));
    hold(8'h0a); hold(8'h0f); hold(8'h05); hold(8'h00);
    settle();
    base = sat_seen;
    check_cnt("count10", 10, base, 0);
    exp_q.push_back(ev(K_ENT, 0)); exp_q.push_back(ev(K_EXT, 1));
    hold(put(0, 2'b10) | put(1, 2'b01));
    hold(put(0, 2'b11) | put(1, 2'b11));
    hold(put(0, 2'b01) | put(1, 2'b10));
    settle();
    check_cnt("net_zero", 10, base, 0);

    // clr in the pulse cycle wins over the pulse
    exp_q.push_back(ev(K_ENT, 0));
    hold(put(0, 2'b10)); hold(put(0, 2'b11)); hold(put(0, 2'b01));
    ab = 8'h00;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (entry_pulse[0] === 1'b1) begin
        got = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
    end
    check("clr_pulse_seen", got, 1);
    settle();
    check_cnt("clr_vs_pulse", 0, base, 0);

    // Reset in EN2 discards the partial pass and the count
    lane_entry(3);
    settle();
    check("pre_rst_count", count, 1);
    hold(put(3, 2'b10)); hold(put(3, 2'b11));
    ab = 8'h00; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_count", count, 0);
    check("midrst_fault", fault, 0);
    base = sat_seen;
    hold(put(3, 2'b01)); hold(put(3, 2'b00));
    settle();
    check_cnt("midrst_after", 0, base, 0);
    check("midrst_fault2", fault, 0);

`ifdef PARKLOT_DEBOUNCE_EN
    // 2-cycle drop of a while in EX3 must not complete an exit
    base = sat_seen;
    hold(put(1, 2'b01)); hold(put(1, 2'b11)); hold(put(1, 2'b10));
    ab = 8'h00; repeat (2) @(negedge clk);
    hold(put(1, 2'b10)); hold(put(1, 2'b11)); hold(put(1, 2'b01));
    settle();
    check_cnt("glitch", 0, base, 0);
    check("glitch_fault", fault, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
